knock_retard_ctrl: RTL and testbench
====================================

// Module: knock_retard_ctrl
// PURPOSE
//   Consumer end of the knock_detected interface: converts knock detections into spark-timing retard.
//   Each new knock retards timing by a fixed step, up to a saturation limit.
//   Retard is held for a quiet period, then stepped back toward zero at a fixed rate.
//   Sits between the knock sensor and the ignition timing stage.
//   Drives the final spark advance as base_advance minus the current retard.
// PARAMETERS
//   RETARD_STEP       4     degrees added to retard per knock event
//   MAX_RETARD        24    saturation ceiling for retard_amt (degrees)
//   HOLD_CYCLES       1000  knock-free clocks required before recovery starts (>=1)
//   RECOVER_STEP      1     degrees removed per recovery tick
//   RECOVER_INTERVAL  250   clocks between recovery ticks (>=1)
//   MIN_ADVANCE       0     floor for spark_advance (degrees)
// PORTS
//   clk             in   1   system clock; all logic on posedge
//   reset           in   1   synchronous, active-high reset
//   knock_detected  in   1   level from knock sensor; may stay high several cycles
//   base_advance    in   8   map spark advance (degrees, unsigned)
//   spark_advance   out  8   corrected advance = max(base_advance - retard_amt, MIN_ADVANCE)
//   retard_amt      out  8   current retard (degrees), 0..MAX_RETARD
//   retard_active   out  1   high whenever state != IDLE
//   knock_count     out  16  count of knock events, saturates at 16'hFFFF
// BEHAVIOUR
//   Reset (synchronous, active-high; overrides every other action):
//     - state=IDLE; retard_amt=0; spark_advance=0; retard_active=0; knock_count=0.
//     - knock_prev=0; hold and interval counters=0.
//     - Mid-operation reset discards all retard immediately.
//   Knock event = rising edge: knock_detected & ~knock_prev. knock_prev is registered every cycle.
//   A level held high yields one event only.
//   States:
//     IDLE    - retard_amt==0. On event: go to HOLD.
//     HOLD    - hold_cnt counts down one per clock.
//               knock_detected high (level) reloads hold_cnt = HOLD_CYCLES-1.
//               hold_cnt==0 with knock_detected low: go to RECOVER; int_cnt = RECOVER_INTERVAL-1.
//     RECOVER - int_cnt counts down one per clock.
//               At int_cnt==0: retard_amt = sat0(retard_amt - RECOVER_STEP); int_cnt reloads.
//               If the result is 0: go to IDLE (retard_active falls the next cycle).
//   Event in any state (highest priority after reset), all in the same cycle:
//     - retard_amt = min(retard_amt + RETARD_STEP, MAX_RETARD); compute the sum in 9 bits.
//     - knock_count += 1, saturating.
//     - hold_cnt = HOLD_CYCLES-1; state = HOLD.
//     - An event coinciding with a recovery tick: the tick is dropped and only the step applies.
//   spark_advance is registered from the current retard_amt and base_advance (1-cycle latency).
//   Subtraction is 9-bit signed. Results below MIN_ADVANCE clamp to MIN_ADVANCE; no wrap.
//   Outputs change only on clk edges; no combinational path from inputs to outputs.
// TESTING (bench params: STEP=4 MAX=12 HOLD=8 RSTEP=1 RINT=4 MIN=0)
//   1. Reset held 3 clks, base_advance=30 -> all outputs 0.
//      First clk after release: spark_advance=30, state IDLE.
//   2. Single 1-clk knock pulse -> next clk retard_amt=4, knock_count=1, retard_active=1.
//      The clk after that: spark_advance=26.
//   3. knock_detected held high 20 clks -> retard_amt stays 4, knock_count=1.
//      RECOVER entered 8 clks after the fall.
//      retard_amt decrements 4->3->2->1->0 every 4 clks, then IDLE and retard_active=0.
//   4. Four pulses 3 clks apart -> retard_amt 4, 8, 12, 12 (saturated); knock_count=4.
//   5. base_advance=5, retard_amt=12 -> spark_advance=0 (clamped, no wrap to 249).
//   6. In RECOVER, knock at the same clk as a recovery tick -> retard goes from 3 to 7, not 6.
//      State HOLD, hold_cnt reloaded.
//      Separately: assert reset mid-HOLD -> all outputs 0 the next clk.

Source files
------------

// File: rtl/knock_retard_ctrl.sv
// knock_retard_ctrl: turns knock-sensor detections into spark-timing retard.
// Each knock rising edge adds a fixed retard step (saturating). After a
// knock-free hold period the retard is walked back to zero at a fixed rate.
// The corrected spark advance is base_advance minus the retard, floored.
//
// Handshake: knock_detected is a plain level, with no valid/ready pairing.
// One event is taken per rising edge, and a level held high yields one event.
// All outputs are registered, so there is no combinational input-to-output path.
module knock_retard_ctrl #(
  parameter int unsigned RETARD_STEP      = 4,
  parameter int unsigned MAX_RETARD       = 24,
  parameter int unsigned HOLD_CYCLES      = 1000,
  parameter int unsigned RECOVER_STEP     = 1,
  parameter int unsigned RECOVER_INTERVAL = 250,
  parameter int unsigned MIN_ADVANCE      = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        knock_detected,
  input  logic [7:0]  base_advance,
  output logic [7:0]  spark_advance,
  output logic [7:0]  retard_amt,
  output logic        retard_active,
  output logic [15:0] knock_count,
  output logic [1:0]  dbg_state
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int IW = (RECOVER_INTERVAL > 1) ? $clog2(RECOVER_INTERVAL) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_knock_prev;
  logic [HW-1:0]   r_hold_cnt;
  logic [IW-1:0]   r_int_cnt;
  logic [7:0]      r_retard;
  logic [7:0]      r_spark;
  logic            r_active;
  logic [15:0]     r_count;

  logic            w_event;
  logic [8:0]      w_sum;
  logic [7:0]      w_stepped;
  logic [7:0]      w_recovered;
  logic signed [8:0] w_diff;
  logic [7:0]      w_spark_next;

  // Combinational helpers: edge detect, saturating step, recovery and clamp math.
  always_comb begin
    w_event      = knock_detected & ~r_knock_prev;
    w_sum        = {1'b0, r_retard} + 9'(RETARD_STEP);
    w_stepped    = (w_sum > 9'(MAX_RETARD)) ? 8'(MAX_RETARD) : w_sum[7:0];
    w_recovered  = (r_retard > 8'(RECOVER_STEP)) ? (r_retard - 8'(RECOVER_STEP)) : 8'd0;
    w_diff       = $signed({1'b0, base_advance}) - $signed({1'b0, r_retard});
    w_spark_next = (w_diff < $signed({1'b0, 8'(MIN_ADVANCE)})) ? 8'(MIN_ADVANCE) : w_diff[7:0];
  end

  // Retard state machine, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_knock_prev <= 1'b0;
      r_hold_cnt   <= '0;
      r_int_cnt    <= '0;
      r_retard     <= 8'd0;
      r_spark      <= 8'd0;
      r_active     <= 1'b0;
      r_count      <= 16'd0;
    end else begin
      r_knock_prev <= knock_detected;
      // Spark uses the retard held before this edge, giving one cycle of latency.
      r_spark      <= w_spark_next;
      if (w_event) begin
        // A new knock wins over everything, including a coincident recovery tick.
        r_retard   <= w_stepped;
        r_count    <= (r_count != 16'hFFFF) ? (r_count + 16'd1) : r_count;
        r_hold_cnt <= HW'(HOLD_CYCLES - 1);
        r_state    <= HOLD;
        r_active   <= 1'b1;
      end else begin
        case (r_state)
          HOLD: begin
            if (knock_detected) begin
              r_hold_cnt <= HW'(HOLD_CYCLES - 1);
            end else if (r_hold_cnt == '0) begin
              r_state   <= RECOVER;
              r_int_cnt <= IW'(RECOVER_INTERVAL - 1);
            end else begin
              r_hold_cnt <= r_hold_cnt - 1'b1;
            end
          end
          RECOVER: begin
            if (r_int_cnt == '0) begin
              r_retard  <= w_recovered;
              r_int_cnt <= IW'(RECOVER_INTERVAL - 1);
              if (w_recovered == 8'd0) begin
                r_state  <= IDLE;
                r_active <= 1'b0;
              end
            end else begin
              r_int_cnt <= r_int_cnt - 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign spark_advance = r_spark;
  assign retard_amt    = r_retard;
  assign retard_active = r_active;
  assign knock_count   = r_count;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_knock_retard_ctrl.sv
// Directed bench for knock_retard_ctrl with small parameters:
// STEP=4 MAX=12 HOLD=8 RSTEP=1 RINT=4 MIN=0.
module tb_knock_retard_ctrl;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HOLD    = 2'd1;
  localparam logic [1:0] S_RECOVER = 2'd2;

  logic        clk;
  logic        reset;
  logic        knock_detected;
  logic [7:0]  base_advance;
  logic [7:0]  spark_advance;
  logic [7:0]  retard_amt;
  logic        retard_active;
  logic [15:0] knock_count;
  logic [1:0]  dbg_state;

  int checks;
  int failures;

  knock_retard_ctrl #(
    .RETARD_STEP(4), .MAX_RETARD(12), .HOLD_CYCLES(8),
    .RECOVER_STEP(1), .RECOVER_INTERVAL(4), .MIN_ADVANCE(0)
  ) dut (
    .clk(clk), .reset(reset), .knock_detected(knock_detected),
    .base_advance(base_advance), .spark_advance(spark_advance),
    .retard_amt(retard_amt), .retard_active(retard_active),
    .knock_count(knock_count), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        knock;
    logic [7:0]  base;
    logic [7:0]  e_retard;
    logic [7:0]  e_spark;
    logic        e_active;
    logic [15:0] e_count;
    logic [1:0]  e_state;
  } vec_t;

  vec_t vecs[13];

  // Advance one clock; outputs are then read 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int e_retard, input int e_spark,
                           input int e_active, input int e_count, input int e_state);
    check({tag, ".retard"}, retard_amt, e_retard);
    check({tag, ".spark"},  spark_advance, e_spark);
    check({tag, ".active"}, retard_active, e_active);
    check({tag, ".count"},  knock_count, e_count);
    check({tag, ".state"},  dbg_state, e_state);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    knock_detected = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Clock knock-low cycles until RECOVER is seen; returns the cycle count (bounded).
  task automatic wait_recover(output int n);
    n = 0;
    knock_detected = 1'b0;
    while (dbg_state != S_RECOVER && n < 50) begin
      tick();
      n++;
    end
  endtask

  // Stimulus and scoreboard
  initial begin
    int n;
    checks = 0;
    failures = 0;

    // knock, base, retard, spark, active, count, state
    vecs[0]  = '{1'b1, 8'd30, 8'd4,  8'd30, 1'b1, 16'd1, S_HOLD};
    vecs[1]  = '{1'b0, 8'd30, 8'd4,  8'd26, 1'b1, 16'd1, S_HOLD};
    vecs[2]  = '{1'b0, 8'd30, 8'd4,  8'd26, 1'b1, 16'd1, S_HOLD};
    vecs[3]  = '{1'b1, 8'd30, 8'd8,  8'd26, 1'b1, 16'd2, S_HOLD};
    vecs[4]  = '{1'b0, 8'd30, 8'd8,  8'd22, 1'b1, 16'd2, S_HOLD};
    vecs[5]  = '{1'b0, 8'd30, 8'd8,  8'd22, 1'b1, 16'd2, S_HOLD};
    vecs[6]  = '{1'b1, 8'd30, 8'd12, 8'd22, 1'b1, 16'd3, S_HOLD};
    vecs[7]  = '{1'b0, 8'd30, 8'd12, 8'd18, 1'b1, 16'd3, S_HOLD};
    vecs[8]  = '{1'b0, 8'd30, 8'd12, 8'd18, 1'b1, 16'd3, S_HOLD};
    vecs[9]  = '{1'b1, 8'd30, 8'd12, 8'd18, 1'b1, 16'd4, S_HOLD};
    vecs[10] = '{1'b0, 8'd30, 8'd12, 8'd18, 1'b1, 16'd4, S_HOLD};
    vecs[11] = '{1'b0, 8'd5,  8'd12, 8'd0,  1'b1, 16'd4, S_HOLD};
    vecs[12] = '{1'b0, 8'd30, 8'd12, 8'd18, 1'b1, 16'd4, S_HOLD};

    // Reset held 3 clocks: everything zero.
    reset = 1'b1;
    knock_detected = 1'b0;
    base_advance = 8'd30;
    for (int i = 0; i < 3; i++) tick();
    check_all("reset", 0, 0, 0, 0, S_IDLE);
    reset = 1'b0;
    tick();
    check_all("post_reset", 0, 30, 0, 0, S_IDLE);

    // Single pulse, pulse train to saturation, clamped spark.
    for (int i = 0; i < 13; i++) begin
      knock_detected = vecs[i].knock;
      base_advance   = vecs[i].base;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].e_retard, vecs[i].e_spark,
                vecs[i].e_active, vecs[i].e_count, vecs[i].e_state);
    end

    // Long knock level: one event, then hold, then stepwise recovery.
    do_reset();
    base_advance = 8'd30;
    knock_detected = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("level%0d.retard", i), retard_amt, 4);
      check($sformatf("level%0d.count", i), knock_count, 1);
    end
    wait_recover(n);
    check("hold_to_recover_cycles", n, 8);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("recover%0d.retard", k), retard_amt, 4 - k / 4);
      check($sformatf("recover%0d.state", k), dbg_state, (k == 16) ? S_IDLE : S_RECOVER);
    end
    check("recover_done.active", retard_active, 0);

    // Knock coinciding with a recovery tick: step wins, tick dropped.
    do_reset();
    knock_detected = 1'b1;
    tick();
    knock_detected = 1'b0;
    wait_recover(n);
    check("coincide.enter_recover", n, 8);
    for (int i = 0; i < 4; i++) tick();
    check("coincide.pre_retard", retard_amt, 3);
    for (int i = 0; i < 3; i++) tick();
    knock_detected = 1'b1;
    tick();
    check("coincide.retard", retard_amt, 7);
    check("coincide.state", dbg_state, S_HOLD);
    check("coincide.count", knock_count, 2);
    knock_detected = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("coincide.hold_reloaded", dbg_state, S_HOLD);
    tick();
    check("coincide.hold_expired", dbg_state, S_RECOVER);

    // Reset asserted mid-HOLD wipes everything on the next clock.
    do_reset();
    knock_detected = 1'b1;
    tick();
    knock_detected = 1'b0;
    tick();
    tick();
    check("midhold.pre_state", dbg_state, S_HOLD);
    reset = 1'b1;
    tick();
    check_all("midhold_reset", 0, 0, 0, 0, S_IDLE);
    reset = 1'b0;
    tick();

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
